// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter sharing the register-file write port
// between NREQ writeback requesters, with one registered write per cycle.
// Optional build macro WB_ZERO_DROP_EN: a granted write to address 0 is
// consumed without raising wb_write.
module regfile_wb_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32,
  localparam int unsigned IW  = $clog2(NREQ)
) (
  input  logic               cclk,
  input  logic               rstb,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               stall,
  output logic               wb_write,
  output logic [AW-1:0]      wb_addr,
  output logic [DW-1:0]      wb_data,
  output logic [IW-1:0]      wb_grant_id
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          wb_write_q, wb_write_d;
  logic [AW-1:0] wb_addr_q, wb_addr_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic [IW-1:0] wb_grant_id_q, wb_grant_id_d;

  logic          found;
  logic [IW-1:0] win;
  int unsigned   idx;
  logic          grant_c;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  // Round-robin scan of req_valid starting at ptr, wrapping NREQ-1 -> 0.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!found && req_valid[IW'(idx)]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  // One-hot grant; suppressed by stall and held low while in reset.
  always_comb begin
    grant_c = found && !stall && rstb;
    for (int i = 0; i < int'(NREQ); i++) begin
      req_ready[i] = grant_c && (win == IW'(i));
    end
  end

  // Select the winning requester's address and data.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (win == IW'(i)) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  // Next-state: a grant advances the pointer past the winner and loads the write.
  always_comb begin
    ptr_d         = ptr_q;
    wb_write_d    = 1'b0;
    wb_addr_d     = wb_addr_q;
    wb_data_d     = wb_data_q;
    wb_grant_id_d = wb_grant_id_q;
    if (grant_c) begin
      ptr_d = (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
`ifdef WB_ZERO_DROP_EN
      // Writes to $zero are consumed here rather than issued.
      if (sel_addr != '0) begin
        wb_write_d    = 1'b1;
        wb_addr_d     = sel_addr;
        wb_data_d     = sel_data;
        wb_grant_id_d = win;
      end
`else
      wb_write_d    = 1'b1;
      wb_addr_d     = sel_addr;
      wb_data_d     = sel_data;
      wb_grant_id_d = win;
`endif
    end
  end

  // State and output registers.
  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      ptr_q         <= '0;
      wb_write_q    <= 1'b0;
      wb_addr_q     <= '0;
      wb_data_q     <= '0;
      wb_grant_id_q <= '0;
    end else begin
      ptr_q         <= ptr_d;
      wb_write_q    <= wb_write_d;
      wb_addr_q     <= wb_addr_d;
      wb_data_q     <= wb_data_d;
      wb_grant_id_q <= wb_grant_id_d;
    end
  end

  assign wb_write    = wb_write_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;
  assign wb_grant_id = wb_grant_id_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios plus a randomized run
// checked against a round-robin reference model. Honors WB_ZERO_DROP_EN.
module tb_regfile_wb_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int IW   = 2;
`ifdef WB_ZERO_DROP_EN
  localparam bit ZDROP = 1'b1;
`else
  localparam bit ZDROP = 1'b0;
`endif

  logic               cclk = 1'b0;
  logic               rstb;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               stall;
  logic               wb_write;
  logic [AW-1:0]      wb_addr;
  logic [DW-1:0]      wb_data;
  logic [IW-1:0]      wb_grant_id;

  logic [AW-1:0] ta [NREQ];
  logic [DW-1:0] td [NREQ];
  assign req_addr = {ta[3], ta[2], ta[1], ta[0]};
  assign req_data = {td[3], td[2], td[1], td[0]};

  int checks = 0;
  int errors = 0;

  // Reference model state
  int            m_ptr;
  logic          m_write;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [IW-1:0] m_id;

  regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .cclk(cclk), .rstb(rstb), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .stall(stall),
    .wb_write(wb_write), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_grant_id(wb_grant_id)
  );

  always #5 cclk = ~cclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Model: first valid requester at or after the pointer, or -1.
  function automatic int m_win();
    if (!rstb || stall) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (req_valid[IW'(i)]) return i;
    end
    return -1;
  endfunction

  // Model: effect of a clock edge given the winner.
  task automatic m_clock(input int w);
    if (w < 0) begin
      m_write = 1'b0;
    end else begin
      m_ptr = (w + 1) % NREQ;
      if (ZDROP && ta[IW'(w)] == '0) begin
        m_write = 1'b0;
      end else begin
        m_write = 1'b1;
        m_addr  = ta[IW'(w)];
        m_data  = td[IW'(w)];
        m_id    = IW'(w);
      end
    end
  endtask

  task automatic do_reset();
    rstb = 1'b0;
    req_valid = '0;
    stall = 1'b0;
    m_ptr = 0; m_write = 1'b0; m_addr = '0; m_data = '0; m_id = '0;
    @(posedge cclk); #1;
    rstb = 1'b1;
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    stall = 1'b0;
    for (int i = 0; i < NREQ; i++) begin ta[i] = 5'(i + 1); td[i] = 32'(i); end
    req_valid = 4'b1111;
    @(posedge cclk); #2;
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    checks++;
    if ({wb_write, wb_addr, wb_data, wb_grant_id} !== '0) begin
      errors++; $display("FAIL reset_outputs got w=%b a=%0d d=%h id=%0d exp all 0", wb_write, wb_addr, wb_data, wb_grant_id);
    end
    req_valid = 4'b0010; ta[1] = 5'd9;
    @(posedge cclk); #1;
    rstb = 1'b1;
    @(posedge cclk); #1;
    checks++;
    if (wb_write !== 1'b1 || wb_addr !== 5'd9) begin errors++; $display("FAIL reset_pre_write got w=%b a=%0d exp w=1 a=9", wb_write, wb_addr); end
    #2 rstb = 1'b0;
    #1;
    checks++;
    if (wb_write !== 1'b0) begin errors++; $display("FAIL reset_async_drop got %b exp 0", wb_write); end
    req_valid = '0;
    @(posedge cclk); #1;
    rstb = 1'b1;
    #1;
    checks++;
    if ({req_ready, wb_write, wb_addr, wb_data, wb_grant_id} !== '0) begin
      errors++; $display("FAIL reset_release got r=%b w=%b a=%0d d=%h id=%0d exp all 0", req_ready, wb_write, wb_addr, wb_data, wb_grant_id);
    end
  endtask

  task automatic test_single();
    do_reset();
    ta[2] = 5'd7; td[2] = 32'hDEADBEEF;
    req_valid = 4'b0100;
    @(negedge cclk);
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b exp 0100", req_ready); end
    @(posedge cclk); #1;
    checks++;
    if ({wb_write, wb_addr, wb_data, wb_grant_id} !== {1'b1, 5'd7, 32'hDEADBEEF, 2'd2}) begin
      errors++; $display("FAIL single_wb got w=%b a=%0d d=%h id=%0d exp w=1 a=7 d=deadbeef id=2", wb_write, wb_addr, wb_data, wb_grant_id);
    end
    req_valid = '0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < NREQ; i++) begin ta[i] = 5'(i + 1); td[i] = 32'h100 + 32'(i); end
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int e;
      logic [NREQ-1:0] er;
      e = k % NREQ;
      er = 4'(1 << e);
      @(negedge cclk);
      checks++;
      if (req_ready !== er) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp %b", k, req_ready, er); end
      @(posedge cclk); #1;
      checks++;
      if (wb_write !== 1'b1 || wb_grant_id !== IW'(e) || wb_addr !== 5'(e + 1)) begin
        errors++; $display("FAIL b2b_wb[%0d] got w=%b id=%0d a=%0d exp w=1 id=%0d a=%0d", k, wb_write, wb_grant_id, wb_addr, e, e + 1);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_stall();
    do_reset();
    ta[1] = 5'd5; td[1] = 32'hCAFE0001;
    req_valid = 4'b0010;
    @(negedge cclk);
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL stall_pre_ready got %b exp 0010", req_ready); end
    @(posedge cclk); #1;
    stall = 1'b1;
    td[1] = 32'hCAFE0002;
    for (int c = 0; c < 3; c++) begin
      @(negedge cclk);
      checks++;
      if (req_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready[%0d] got %b exp 0000", c, req_ready); end
      if (c == 0) begin
        checks++;
        if (wb_write !== 1'b1 || wb_data !== 32'hCAFE0001) begin
          errors++; $display("FAIL stall_present got w=%b d=%h exp w=1 d=cafe0001", wb_write, wb_data);
        end
      end
      @(posedge cclk); #1;
      checks++;
      if (wb_write !== 1'b0) begin errors++; $display("FAIL stall_write[%0d] got %b exp 0", c, wb_write); end
    end
    stall = 1'b0;
    @(negedge cclk);
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL stall_release_ready got %b exp 0010", req_ready); end
    @(posedge cclk); #1;
    checks++;
    if (wb_write !== 1'b1 || wb_grant_id !== 2'd1 || wb_data !== 32'hCAFE0002) begin
      errors++; $display("FAIL stall_release_wb got w=%b id=%0d d=%h exp w=1 id=1 d=cafe0002", wb_write, wb_grant_id, wb_data);
    end
    req_valid = '0;
  endtask

  task automatic test_wrap();
    do_reset();
    ta[2] = 5'd3;
    req_valid = 4'b0100;
    @(posedge cclk); #1;
    ta[0] = 5'd10; ta[1] = 5'd11;
    req_valid = 4'b0011;
    @(negedge cclk);
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_first got %b exp 0001", req_ready); end
    @(posedge cclk); #1;
    @(negedge cclk);
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL wrap_second got %b exp 0010", req_ready); end
    @(posedge cclk); #1;
    checks++;
    if (wb_grant_id !== 2'd1 || wb_addr !== 5'd11) begin
      errors++; $display("FAIL wrap_wb got id=%0d a=%0d exp id=1 a=11", wb_grant_id, wb_addr);
    end
    req_valid = '0;
  endtask

  task automatic test_zero_addr();
    do_reset();
    ta[1] = 5'd6; td[1] = 32'h66;
    req_valid = 4'b0010;
    @(posedge cclk); #1;
    ta[0] = 5'd0; td[0] = 32'h12345678;
    req_valid = 4'b0001;
    @(negedge cclk);
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL zero_ready got %b exp 0001", req_ready); end
    @(posedge cclk); #1;
    checks++;
`ifdef WB_ZERO_DROP_EN
    if ({wb_write, wb_addr, wb_data, wb_grant_id} !== {1'b0, 5'd6, 32'h66, 2'd1}) begin
      errors++; $display("FAIL zero_drop got w=%b a=%0d d=%h id=%0d exp w=0 a=6 d=66 id=1", wb_write, wb_addr, wb_data, wb_grant_id);
    end
`else
    if ({wb_write, wb_addr, wb_data, wb_grant_id} !== {1'b1, 5'd0, 32'h12345678, 2'd0}) begin
      errors++; $display("FAIL zero_issue got w=%b a=%0d d=%h id=%0d exp w=1 a=0 d=12345678 id=0", wb_write, wb_addr, wb_data, wb_grant_id);
    end
`endif
    ta[1] = 5'd8;
    req_valid = 4'b0011;
    @(negedge cclk);
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL zero_ptr_adv got %b exp 0010", req_ready); end
    @(posedge cclk); #1;
    req_valid = '0;
  endtask

  task automatic test_random();
    logic [NREQ-1:0] pend;
    int waits [NREQ];
    do_reset();
    pend = '0;
    for (int i = 0; i < NREQ; i++) waits[i] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int w;
      logic [NREQ-1:0] er;
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom % 2 == 0)) begin
          pend[i] = 1'b1;
          ta[i] = 5'($urandom_range(0, 31));
          td[i] = $urandom;
          waits[i] = 0;
        end
      end
      req_valid = pend;
      stall = ($urandom % 4 == 0);
      @(negedge cclk);
      w = m_win();
      er = (w < 0) ? '0 : 4'(1 << w);
      checks++;
      if (req_ready !== er) begin errors++; $display("FAIL rand_ready[%0d] got %b exp %b", cyc, req_ready, er); end
      @(posedge cclk);
      m_clock(w);
      if (w >= 0) begin
        checks++;
        if (waits[w] > NREQ - 1) begin errors++; $display("FAIL rand_fair[%0d] req %0d waited %0d transfers exp <= %0d", cyc, w, waits[w], NREQ - 1); end
        pend[IW'(w)] = 1'b0;
        for (int i = 0; i < NREQ; i++) if (pend[i]) waits[i]++;
      end
      #1;
      checks++;
      if ({wb_write, wb_addr, wb_data, wb_grant_id} !== {m_write, m_addr, m_data, m_id}) begin
        errors++; $display("FAIL rand_wb[%0d] got w=%b a=%0d d=%h id=%0d exp w=%b a=%0d d=%h id=%0d",
                           cyc, wb_write, wb_addr, wb_data, wb_grant_id, m_write, m_addr, m_data, m_id);
      end
    end
    req_valid = '0;
    stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_wrap();
    test_zero_addr();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
